ram_arbiter: RTL and testbench

Two-port access arbiter for the shared RAM8 built from the project-03 register cells. Two requesters, such as a CPU data port and a loader/DMA port, each issue single-word read or write requests over a req/ack handshake. The arbiter grants one requester at a time, drives the RAM8 load/address/data lines for exactly one clock, returns read data, and acks the winner.

---
 rtl/ram_arb_pkg.sv | 23 ++
 rtl/ram_arb_grant.sv | 26 ++
 rtl/ram_arbiter.sv | 152 +++++++++++++++
 tb/tb_ram_arbiter.sv | 304 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ram_arb_pkg.sv
// Shared types for the two-port RAM8 arbiter: FSM states, default sizes and port ids.
package ram_arb_pkg;

    localparam int DEF_WIDTH  = 16;
    localparam int DEF_ADDR_W = 3;
    localparam int NUM_PORTS  = 2;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_ACK    = 2'd2
    } state_e;

    typedef logic port_id_t;

    localparam port_id_t PORT0 = 1'b0;
    localparam port_id_t PORT1 = 1'b1;

    function automatic port_id_t other_port(input port_id_t p);
        return ~p;
    endfunction

endpackage

// File: rtl/ram_arb_grant.sv
// Combinational winner select for two requesters; masked ports never win, ties go to the pointer.
module ram_arb_grant
    import ram_arb_pkg::*;
(
    input  logic     req0_i,
    input  logic     req1_i,
    input  logic [1:0] mask_i,
    input  port_id_t ptr_i,
    output logic     gnt_valid_o,
    output port_id_t gnt_id_o
);

    logic [1:0] live;

    always_comb begin
        live        = {req1_i, req0_i} & ~mask_i;
        gnt_valid_o = |live;
        gnt_id_o    = PORT0;
        if (live == 2'b11) begin
            gnt_id_o = ptr_i;
        end else if (live[1]) begin
            gnt_id_o = PORT1;
        end
    end

endmodule

// File: rtl/ram_arbiter.sv
// Two-port req/ack arbiter driving a RAM8 for one cycle per access.
// RAM_ARB_RR_EN selects round-robin tie breaking; otherwise port 0 always wins ties.
module ram_arbiter
    import ram_arb_pkg::*;
#(
    parameter int WIDTH  = DEF_WIDTH,
    parameter int ADDR_W = DEF_ADDR_W
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req0,
    input  logic              req1,
    input  logic              we0,
    input  logic              we1,
    input  logic [ADDR_W-1:0] addr0,
    input  logic [ADDR_W-1:0] addr1,
    input  logic [WIDTH-1:0]  wdata0,
    input  logic [WIDTH-1:0]  wdata1,
    output logic              ack0,
    output logic              ack1,
    output logic [WIDTH-1:0]  rdata,
    output logic              mem_load,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [WIDTH-1:0]  mem_in,
    input  logic [WIDTH-1:0]  mem_out
);

    state_e            state_q, state_d;
    logic              we_q, we_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [WIDTH-1:0]  wdata_q, wdata_d;
    logic [WIDTH-1:0]  rdata_q, rdata_d;
    port_id_t          port_q, port_d;

    logic              gnt_valid;
    port_id_t          gnt_id;
    port_id_t          ptr;
    logic              grant;
    logic [1:0]        mask;

    // Per-port request fields gathered into arrays so the grant id indexes them directly.
    logic              req_we   [NUM_PORTS];
    logic [ADDR_W-1:0] req_addr [NUM_PORTS];
    logic [WIDTH-1:0]  req_wdata[NUM_PORTS];
    logic [1:0]        ack_vec;

    assign req_we[0]    = we0;
    assign req_we[1]    = we1;
    assign req_addr[0]  = addr0;
    assign req_addr[1]  = addr1;
    assign req_wdata[0] = wdata0;
    assign req_wdata[1] = wdata1;

    generate
        for (genvar gi = 0; gi < NUM_PORTS; gi++) begin : g_port
            assign ack_vec[gi] = (state_q == ST_ACK) && (port_q == port_id_t'(gi));
            // The port being acked only now learns of completion, so its held req is stale.
            assign mask[gi]    = ack_vec[gi];
        end
    endgenerate

    ram_arb_grant u_grant (
        .req0_i     (req0),
        .req1_i     (req1),
        .mask_i     (mask),
        .ptr_i      (ptr),
        .gnt_valid_o(gnt_valid),
        .gnt_id_o   (gnt_id)
    );

`ifdef RAM_ARB_RR_EN
    port_id_t ptr_q, ptr_d;

    always_comb begin
        ptr_d = ptr_q;
        if (grant) begin
            ptr_d = other_port(gnt_id);
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ptr_q <= PORT0;
        end else begin
            ptr_q <= ptr_d;
        end
    end

    assign ptr = ptr_q;
`else
    assign ptr = PORT0;
`endif

    always_comb begin
        state_d = state_q;
        we_d    = we_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        port_d  = port_q;
        rdata_d = rdata_q;
        grant   = 1'b0;
        case (state_q)
            ST_IDLE, ST_ACK: begin
                state_d = ST_IDLE;
                if (gnt_valid) begin
                    grant   = 1'b1;
                    state_d = ST_ACCESS;
                    port_d  = gnt_id;
                    we_d    = req_we[gnt_id];
                    addr_d  = req_addr[gnt_id];
                    wdata_d = req_wdata[gnt_id];
                end
            end
            ST_ACCESS: begin
                state_d = ST_ACK;
                if (!we_q) begin
                    rdata_d = mem_out;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= ST_IDLE;
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
            port_q  <= PORT0;
        end else begin
            state_q <= state_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
            port_q  <= port_d;
        end
    end

    // Decoded from the async-reset state so a reset mid-access kills the strobe at once.
    assign mem_load = (state_q == ST_ACCESS) && we_q;
    assign mem_addr = addr_q;
    assign mem_in   = wdata_q;
    assign rdata    = rdata_q;
    assign ack0     = ack_vec[0];
    assign ack1     = ack_vec[1];

endmodule

// File: tb/tb_ram_arbiter.sv
// Self-checking bench for ram_arbiter: directed scenarios plus randomized traffic against a transaction model.
`timescale 1ns/1ps
module tb_ram_arbiter;

    localparam int W  = 16;
    localparam int AW = 3;

    logic          clk = 1'b0;
    logic          reset;
    logic          req0, req1, we0, we1;
    logic [AW-1:0] addr0, addr1;
    logic [W-1:0]  wdata0, wdata1;
    logic          ack0, ack1;
    logic [W-1:0]  rdata;
    logic          mem_load;
    logic [AW-1:0] mem_addr;
    logic [W-1:0]  mem_in;
    logic [W-1:0]  mem_out;

    logic [W-1:0]  ram [8];

    int checks = 0;
    int errors = 0;

    // Reference model: one transaction in flight at most, either being accessed or being acked.
    logic [W-1:0]  ref_mem [8];
    int            m_cur;
    bit            m_acked;
    int            m_ptr;
    logic          m_we;
    logic [AW-1:0] m_addr;
    logic [W-1:0]  m_wdata;
    logic [W-1:0]  m_rdata;

    always #5 clk = ~clk;

    ram_arbiter #(.WIDTH(W), .ADDR_W(AW)) dut (
        .clk     (clk),
        .reset   (reset),
        .req0    (req0),
        .req1    (req1),
        .we0     (we0),
        .we1     (we1),
        .addr0   (addr0),
        .addr1   (addr1),
        .wdata0  (wdata0),
        .wdata1  (wdata1),
        .ack0    (ack0),
        .ack1    (ack1),
        .rdata   (rdata),
        .mem_load(mem_load),
        .mem_addr(mem_addr),
        .mem_in  (mem_in),
        .mem_out (mem_out)
    );

    always @(posedge clk) if (mem_load) ram[mem_addr] <= mem_in;
    assign mem_out = ram[mem_addr];

    task automatic pulse_reset();
        reset = 1'b0;
        @(negedge clk);
        reset = 1'b1;
    endtask

    // Issue one request from port p starting at a negedge and wait for its ack.
    task automatic xfer(input int p, input logic we, input logic [AW-1:0] a, input logic [W-1:0] d,
                        output int lat, output logic [W-1:0] rd);
        lat = -1;
        rd  = '0;
        if (p == 0) begin req0 = 1'b1; we0 = we; addr0 = a; wdata0 = d; end
        else        begin req1 = 1'b1; we1 = we; addr1 = a; wdata1 = d; end
        for (int i = 1; i <= 12; i++) begin
            @(negedge clk);
            if ((p == 0 && ack0 === 1'b1) || (p == 1 && ack1 === 1'b1)) begin
                lat = i;
                rd  = rdata;
                break;
            end
        end
        if (p == 0) req0 = 1'b0; else req1 = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_reset();
        reset = 1'b0;
        req0 = 1'b1; we0 = 1'b1; addr0 = 3'd0; wdata0 = 16'h0000;
        repeat (2) @(negedge clk);
        checks++; if (ack0 !== 1'b0) begin errors++; $display("FAIL reset_ack0 got %b want 0", ack0); end
        checks++; if (ack1 !== 1'b0) begin errors++; $display("FAIL reset_ack1 got %b want 0", ack1); end
        checks++; if (mem_load !== 1'b0) begin errors++; $display("FAIL reset_mem_load got %b want 0", mem_load); end
        checks++; if (rdata !== 16'h0) begin errors++; $display("FAIL reset_rdata got %h want 0000", rdata); end
        checks++; if (mem_addr !== 3'd0 || mem_in !== 16'h0) begin errors++; $display("FAIL reset_mem_bus got %0d/%h want 0/0000", mem_addr, mem_in); end
        reset = 1'b1;
        @(negedge clk);
        checks++; if (ack0 !== 1'b0 || mem_load !== 1'b1) begin errors++; $display("FAIL reset_first_access ack0=%b load=%b want 0/1", ack0, mem_load); end
        @(negedge clk);
        checks++; if (ack0 !== 1'b1) begin errors++; $display("FAIL reset_ack_latency ack0=%b want 1", ack0); end
        req0 = 1'b0;
        @(negedge clk);
        checks++; if (ack0 !== 1'b0) begin errors++; $display("FAIL reset_ack_width ack0=%b want 0", ack0); end
    endtask

    task automatic test_write_read();
        int lat;
        logic [W-1:0] rd;
        req0 = 1'b1; we0 = 1'b1; addr0 = 3'd5; wdata0 = 16'hBEEF;
        @(negedge clk);
        checks++; if (mem_load !== 1'b1 || mem_addr !== 3'd5 || mem_in !== 16'hBEEF) begin errors++; $display("FAIL wr_access load=%b addr=%0d in=%h want 1/5/beef", mem_load, mem_addr, mem_in); end
        checks++; if (ack0 !== 1'b0) begin errors++; $display("FAIL wr_early_ack ack0=%b want 0", ack0); end
        @(negedge clk);
        checks++; if (mem_load !== 1'b0 || ack0 !== 1'b1) begin errors++; $display("FAIL wr_ack load=%b ack0=%b want 0/1", mem_load, ack0); end
        req0 = 1'b0;
        @(negedge clk);
        xfer(0, 1'b0, 3'd5, 16'h0, lat, rd);
        checks++; if (lat !== 2) begin errors++; $display("FAIL rd_latency got %0d want 2", lat); end
        checks++; if (rd !== 16'hBEEF) begin errors++; $display("FAIL rd_data got %h want beef", rd); end
    endtask

    task automatic run_contention(input logic [W-1:0] d0, input logic [W-1:0] d1,
                                  output int t0, output int t1, output int both);
        t0 = -1; t1 = -1; both = 0;
        req0 = 1'b1; we0 = 1'b1; addr0 = 3'd2; wdata0 = d0;
        req1 = 1'b1; we1 = 1'b1; addr1 = 3'd2; wdata1 = d1;
        for (int i = 1; i <= 10; i++) begin
            @(negedge clk);
            if (ack0 === 1'b1 && ack1 === 1'b1) both++;
            if (ack0 === 1'b1 && t0 < 0) begin t0 = i; req0 = 1'b0; end
            if (ack1 === 1'b1 && t1 < 0) begin t1 = i; req1 = 1'b0; end
        end
    endtask

    task automatic test_contention();
        int t0, t1, both, lat;
        logic [W-1:0] rd;
        int e0, e1;
        logic [W-1:0] erd;
        pulse_reset();
        run_contention(16'h0001, 16'h0002, t0, t1, both);
        checks++; if (t0 !== 2 || t1 !== 4) begin errors++; $display("FAIL cont1_order ack0@%0d ack1@%0d want 2/4", t0, t1); end
        checks++; if (both !== 0) begin errors++; $display("FAIL cont1_coincident got %0d want 0", both); end
        xfer(0, 1'b0, 3'd2, 16'h0, lat, rd);
        checks++; if (rd !== 16'h0002 || lat !== 2) begin errors++; $display("FAIL cont1_read got %h lat %0d want 0002 lat 2", rd, lat); end
        run_contention(16'h0003, 16'h0004, t0, t1, both);
`ifdef RAM_ARB_RR_EN
        e0 = 4; e1 = 2; erd = 16'h0003;
`else
        e0 = 2; e1 = 4; erd = 16'h0004;
`endif
        checks++; if (t0 !== e0 || t1 !== e1) begin errors++; $display("FAIL cont2_order ack0@%0d ack1@%0d want %0d/%0d", t0, t1, e0, e1); end
        xfer(0, 1'b0, 3'd2, 16'h0, lat, rd);
        checks++; if (rd !== erd) begin errors++; $display("FAIL cont2_read got %h want %h", rd, erd); end
    endtask

    task automatic test_back_to_back();
        int n, both;
        pulse_reset();
        n = 0; both = 0;
        req0 = 1'b1; we0 = 1'b0; addr0 = 3'd0;
        req1 = 1'b1; we1 = 1'b0; addr1 = 3'd2;
        for (int i = 1; i <= 40 && n < 8; i++) begin
            @(negedge clk);
            if (ack0 === 1'b1 && ack1 === 1'b1) both++;
            if (ack0 === 1'b1 || ack1 === 1'b1) begin
                n++;
                checks++;
                if ((ack1 === 1'b1 ? 1 : 0) !== ((n - 1) % 2) || i !== 2 * n) begin
                    errors++;
                    $display("FAIL b2b_ack%0d port=%0d cycle=%0d want port=%0d cycle=%0d", n, ack1 === 1'b1 ? 1 : 0, i, (n - 1) % 2, 2 * n);
                end
            end
        end
        req0 = 1'b0; req1 = 1'b0;
        checks++; if (n !== 8) begin errors++; $display("FAIL b2b_count got %0d want 8", n); end
        checks++; if (both !== 0) begin errors++; $display("FAIL b2b_coincident got %0d want 0", both); end
        repeat (2) @(negedge clk);
    endtask

    task automatic test_abort();
        int lat, stray;
        logic [W-1:0] rd;
        xfer(0, 1'b1, 3'd7, 16'hAAAA, lat, rd);
        checks++; if (lat !== 2) begin errors++; $display("FAIL abort_prewrite lat=%0d want 2", lat); end
        req0 = 1'b1; we0 = 1'b1; addr0 = 3'd7; wdata0 = 16'h1234;
        @(negedge clk);
        checks++; if (mem_load !== 1'b1) begin errors++; $display("FAIL abort_in_access load=%b want 1", mem_load); end
        #2 reset = 1'b0;
        #1;
        checks++; if (mem_load !== 1'b0) begin errors++; $display("FAIL abort_async_load load=%b want 0", mem_load); end
        req0 = 1'b0;
        stray = 0;
        @(negedge clk);
        if (ack0 !== 1'b0) stray++;
        reset = 1'b1;
        repeat (3) begin
            @(negedge clk);
            if (ack0 !== 1'b0) stray++;
        end
        checks++; if (stray !== 0) begin errors++; $display("FAIL abort_no_ack stray=%0d want 0", stray); end
        xfer(0, 1'b0, 3'd7, 16'h0, lat, rd);
        checks++; if (rd !== 16'hAAAA) begin errors++; $display("FAIL abort_old_value got %h want aaaa", rd); end
    endtask

    task automatic test_hold();
        int lat;
        logic [W-1:0] rd;
        xfer(1, 1'b1, 3'd3, 16'h1111, lat, rd);
        xfer(1, 1'b1, 3'd4, 16'h4444, lat, rd);
        req0 = 1'b1; we0 = 1'b0; addr0 = 3'd3;
        @(negedge clk);
        checks++; if (mem_addr !== 3'd3) begin errors++; $display("FAIL hold_access_addr got %0d want 3", mem_addr); end
        addr0 = 3'd4;
        @(negedge clk);
        checks++; if (ack0 !== 1'b1 || rdata !== 16'h1111 || mem_addr !== 3'd3) begin errors++; $display("FAIL hold_isolation ack0=%b rdata=%h addr=%0d want 1/1111/3", ack0, rdata, mem_addr); end
        req0 = 1'b0;
        @(negedge clk);
    endtask

    // Advance the reference model across one rising edge using the currently driven inputs.
    task automatic model_step();
        bit c0, c1;
        int win;
        if (m_cur >= 0 && !m_acked) begin
            if (m_we) ref_mem[m_addr] = m_wdata;
            else      m_rdata = ref_mem[m_addr];
            m_acked = 1'b1;
        end else begin
            c0 = req0 && !(m_cur == 0);
            c1 = req1 && !(m_cur == 1);
            if (c0 || c1) begin
                win = (c0 && c1) ? m_ptr : (c1 ? 1 : 0);
`ifdef RAM_ARB_RR_EN
                m_ptr = 1 - win;
`endif
                m_cur   = win;
                m_acked = 1'b0;
                m_we    = (win == 0) ? we0 : we1;
                m_addr  = (win == 0) ? addr0 : addr1;
                m_wdata = (win == 0) ? wdata0 : wdata1;
            end else begin
                m_cur   = -1;
                m_acked = 1'b0;
            end
        end
    endtask

    task automatic test_random();
        int lat;
        logic [W-1:0] rd, v;
        logic e_ack0, e_ack1, e_load;
        for (int a = 0; a < 8; a++) begin
            v = 16'($urandom);
            xfer(1, 1'b1, 3'(a), v, lat, rd);
            ref_mem[a] = v;
        end
        pulse_reset();
        m_cur = -1; m_acked = 1'b0; m_ptr = 0;
        m_we = 1'b0; m_addr = '0; m_wdata = '0; m_rdata = '0;
        for (int cyc = 0; cyc < 300; cyc++) begin
            e_ack0 = (m_cur == 0) && m_acked;
            e_ack1 = (m_cur == 1) && m_acked;
            e_load = (m_cur >= 0) && !m_acked && m_we;
            checks++; if (ack0 !== e_ack0 || ack1 !== e_ack1) begin errors++; $display("FAIL rnd_ack cyc=%0d got %b%b want %b%b", cyc, ack1, ack0, e_ack1, e_ack0); end
            checks++; if (mem_load !== e_load) begin errors++; $display("FAIL rnd_load cyc=%0d got %b want %b", cyc, mem_load, e_load); end
            checks++; if (rdata !== m_rdata) begin errors++; $display("FAIL rnd_rdata cyc=%0d got %h want %h", cyc, rdata, m_rdata); end
            checks++; if (mem_addr !== m_addr || mem_in !== m_wdata) begin errors++; $display("FAIL rnd_bus cyc=%0d got %0d/%h want %0d/%h", cyc, mem_addr, mem_in, m_addr, m_wdata); end
            if (e_ack0 || e_ack1)
                $display("txn port%0d %s addr=%0d data=%h", m_cur, m_we ? "wr" : "rd", m_addr, m_we ? m_wdata : m_rdata);
            if (req0 && e_ack0) begin
                if ($urandom_range(1, 0) == 1) begin we0 = 1'($urandom_range(1, 0)); addr0 = 3'($urandom_range(7, 0)); wdata0 = 16'($urandom); end
                else req0 = 1'b0;
            end else if (!req0 && $urandom_range(2, 0) == 0) begin
                req0 = 1'b1; we0 = 1'($urandom_range(1, 0)); addr0 = 3'($urandom_range(7, 0)); wdata0 = 16'($urandom);
            end
            if (req1 && e_ack1) begin
                if ($urandom_range(1, 0) == 1) begin we1 = 1'($urandom_range(1, 0)); addr1 = 3'($urandom_range(7, 0)); wdata1 = 16'($urandom); end
                else req1 = 1'b0;
            end else if (!req1 && $urandom_range(2, 0) == 0) begin
                req1 = 1'b1; we1 = 1'($urandom_range(1, 0)); addr1 = 3'($urandom_range(7, 0)); wdata1 = 16'($urandom);
            end
            model_step();
            @(negedge clk);
        end
        req0 = 1'b0; req1 = 1'b0;
        repeat (4) @(negedge clk);
    endtask

    initial begin
        reset = 1'b0;
        req0 = 1'b0; req1 = 1'b0; we0 = 1'b0; we1 = 1'b0;
        addr0 = '0; addr1 = '0; wdata0 = '0; wdata1 = '0;
        @(negedge clk);
        test_reset();
        test_write_read();
        test_contention();
        test_back_to_back();
        test_abort();
        test_hold();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
